// File: rtl/gon_y_collector_pkg.sv
// Shared definitions for the GON Y-bus collector.
//   - Default bus field widths and FIFO depth.
//   - FSM state encoding (IDLE=0, RUN=1, DRAIN=2).
//   - Helpers that give the flag-bit position inside ready_tag and enable_value.
package gon_y_collector_pkg;

    localparam int ID_LEN_DEF     = 5;
    localparam int ROW_LEN_DEF    = 4;
    localparam int VALUE_LEN_DEF  = 32;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // ready_tag = {ready, row_tag, col_id}: the ready flag sits above both tag fields.
    function automatic int ready_bit_pos(input int row_len, input int id_len);
        return row_len + id_len;
    endfunction

    // enable_value = {enable, value}: the enable flag sits above the payload.
    function automatic int enable_bit_pos(input int value_len);
        return value_len;
    endfunction

endpackage

// File: rtl/gon_y_collector_if.sv
// Bus bundle seen by the collector.
//   ready_tag    : {ready, row_tag, col_id} sourced by the collector toward the Y bus
//   enable_value : {enable, value} returned by the Y bus
//   out_valid/out_data/out_ready : FIFO head stream toward the GLB write port
// master = collector side, slave = Y bus / GLB side.
interface gon_y_collector_if
    import gon_y_collector_pkg::*;
#(
    parameter int ID_LEN    = ID_LEN_DEF,
    parameter int ROW_LEN   = ROW_LEN_DEF,
    parameter int VALUE_LEN = VALUE_LEN_DEF
);
    logic [ROW_LEN+ID_LEN:0]           ready_tag;
    logic [VALUE_LEN:0]                enable_value;
    logic                              out_valid;
    logic [ROW_LEN+ID_LEN+VALUE_LEN-1:0] out_data;
    logic                              out_ready;

    modport master (
        output ready_tag,
        input  enable_value,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  ready_tag,
        output enable_value,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/gon_y_collector_fifo.sv
// gon_sync_fifo: synchronous FIFO with a register-array head.
//   clk, rst (sync, active-low) | push, din | pop, dout | full, empty, count
// dout reads 0 while empty so the downstream data bus is clean when nothing is valid.
module gon_sync_fifo
    import gon_y_collector_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/gon_y_collector.sv
// gon_y_collector: slave-side gather engine for one GON Y bus.
// Walks a (row, col-id) tag window row-major, drives ready_tag, captures each value
// returned on enable_value and queues {row_tag, col_id, value} toward the GLB.
//   clk, rst          : clock, synchronous active-low reset
//   start, cfg_*      : window configuration, latched on start while idle
//   bus (master)      : ready_tag / enable_value / out_valid / out_data / out_ready
//   busy, done        : state != IDLE, one-cycle pulse on DRAIN->IDLE
module gon_y_collector
    import gon_y_collector_pkg::*;
#(
    parameter int ID_LEN     = ID_LEN_DEF,
    parameter int ROW_LEN    = ROW_LEN_DEF,
    parameter int VALUE_LEN  = VALUE_LEN_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROW_LEN-1:0]   cfg_row_base,
    input  logic [ROW_LEN:0]     cfg_row_cnt,
    input  logic [ID_LEN-1:0]    cfg_col_base,
    input  logic [ID_LEN:0]      cfg_col_cnt,
    gon_y_collector_if.master    bus,
    output logic                 busy,
    output logic                 done
);
    localparam int READY_POS  = ready_bit_pos(ROW_LEN, ID_LEN);
    localparam int ENABLE_POS = enable_bit_pos(VALUE_LEN);
    localparam int OUT_W      = ROW_LEN + ID_LEN + VALUE_LEN;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    state_t state, state_nxt;
    logic   done_nxt;

    logic [ROW_LEN-1:0] row_base;
    logic [ROW_LEN:0]   row_cnt;
    logic [ID_LEN-1:0]  col_base;
    logic [ID_LEN:0]    col_cnt;
    logic [ROW_LEN:0]   row_idx;
    logic [ID_LEN:0]    col_idx;

    logic [ROW_LEN-1:0] row_tag;
    logic [ID_LEN-1:0]  col_id;
    logic [ROW_LEN:0]   row_last;
    logic [ID_LEN:0]    col_last;
    logic               last_col;
    logic               last_row;
    logic               ready;
    logic               beat;
    logic               pop;

    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [OUT_W-1:0]   fifo_din;

    // Tags wrap modulo their field width by plain truncated addition.
    assign row_tag  = row_base + row_idx[ROW_LEN-1:0];
    assign col_id   = col_base + col_idx[ID_LEN-1:0];
    assign row_last = row_cnt - {{ROW_LEN{1'b0}}, 1'b1};
    assign col_last = col_cnt - {{ID_LEN{1'b0}}, 1'b1};
    assign last_col = (col_idx == col_last);
    assign last_row = (row_idx == row_last);

    // ready depends only on registered state and the registered FIFO count, so a pop
    // in a full cycle re-opens ready one cycle later and there is no path from enable.
    assign ready = (state == ST_RUN) && !fifo_full;
    assign beat  = ready && bus.enable_value[ENABLE_POS];
    assign pop   = bus.out_ready && bus.out_valid;

    assign bus.ready_tag[READY_POS]     = ready;
    assign bus.ready_tag[READY_POS-1:0] = {row_tag, col_id};
    assign bus.out_valid                = !fifo_empty;

    assign fifo_din = {row_tag, col_id, bus.enable_value[VALUE_LEN-1:0]};
    assign busy     = (state != ST_IDLE);

    gon_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (beat),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (bus.out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // An empty window has nothing to gather: go straight to draining.
                    if (cfg_row_cnt == '0 || cfg_col_cnt == '0) state_nxt = ST_DRAIN;
                    else                                        state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat && last_col && last_row) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_count == '0) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    // Window configuration is captured only when a start is honoured in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_base <= '0;
            row_cnt  <= '0;
            col_base <= '0;
            col_cnt  <= '0;
            row_idx  <= '0;
            col_idx  <= '0;
        end else if (state == ST_IDLE && start) begin
            row_base <= cfg_row_base;
            row_cnt  <= cfg_row_cnt;
            col_base <= cfg_col_base;
            col_cnt  <= cfg_col_cnt;
            row_idx  <= '0;
            col_idx  <= '0;
        end else if (beat) begin
            if (last_col) begin
                col_idx <= '0;
                row_idx <= row_idx + 1'b1;
            end else begin
                col_idx <= col_idx + 1'b1;
            end
        end
    end

endmodule
